// File: rtl/min_max_tracker.sv
// min_max_tracker: running minimum / maximum / saturating count / trend of an
// unsigned sample stream, with a frozen report presented over a second
// valid/ready handshake.
module min_max_tracker #(
   parameter int DATA_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              report_req,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] min_out,
   output logic [DATA_W-1:0] max_out,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              trend_e,
   output logic              trend_l,
   output logic              trend_g
);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      TRACK  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state_reg;
   logic [DATA_W-1:0]   min_reg;
   logic [DATA_W-1:0]   max_reg;
   logic [DATA_W-1:0]   prev_reg;
   logic [CNT_W-1:0]    count_reg;
   logic                empty_reg;
   logic                trend_e_reg;
   logic                trend_l_reg;
   logic                trend_g_reg;

   logic                accept;
   logic                first_sample;
   logic                below_min;
   logic                above_max;
   logic                prev_eq;
   logic                prev_lt;
   logic                prev_gt;

   // Handshake flags decode straight from the state; rst forces both low.
   assign in_ready  = ~rst & (state_reg != REPORT);
   assign out_valid = ~rst & (state_reg == REPORT);

   assign accept       = in_valid & in_ready;
   // A sample that lands while clear is high restarts the statistics.
   assign first_sample = accept & (clear | (state_reg == EMPTY));

   // Magnitude compares of the incoming sample against the tracked values.
   always_comb begin
      below_min = (in_data < min_reg);
      above_max = (in_data > max_reg);
      prev_eq   = (in_data == prev_reg);
      prev_lt   = (in_data < prev_reg);
      prev_gt   = (in_data > prev_reg);
   end

   // Statistics registers and control state machine.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= EMPTY;
         min_reg     <= '0;
         max_reg     <= '0;
         prev_reg    <= '0;
         count_reg   <= '0;
         empty_reg   <= 1'b1;
         trend_e_reg <= 1'b0;
         trend_l_reg <= 1'b0;
         trend_g_reg <= 1'b0;
      end else begin
         case (state_reg)
            EMPTY, TRACK: begin
               if (first_sample) begin
                  min_reg     <= in_data;
                  max_reg     <= in_data;
                  prev_reg    <= in_data;
                  count_reg   <= {{(CNT_W-1){1'b0}}, 1'b1};
                  empty_reg   <= 1'b0;
                  trend_e_reg <= 1'b0;
                  trend_l_reg <= 1'b0;
                  trend_g_reg <= 1'b0;
               end else if (accept) begin
                  if (below_min) min_reg <= in_data;
                  if (above_max) max_reg <= in_data;
                  prev_reg    <= in_data;
                  // Saturate rather than wrap so a long stream never looks short.
                  count_reg   <= (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
                  trend_e_reg <= prev_eq;
                  trend_l_reg <= prev_lt;
                  trend_g_reg <= prev_gt;
               end else if (clear) begin
                  min_reg     <= '0;
                  max_reg     <= '0;
                  prev_reg    <= '0;
                  count_reg   <= '0;
                  empty_reg   <= 1'b1;
                  trend_e_reg <= 1'b0;
                  trend_l_reg <= 1'b0;
                  trend_g_reg <= 1'b0;
               end

               // A report request wins; the same-cycle sample/clear is already
               // folded into the registers above, so the report includes it.
               if (report_req) begin
                  state_reg <= REPORT;
               end else if (accept) begin
                  state_reg <= TRACK;
               end else if (clear) begin
                  state_reg <= EMPTY;
               end
            end

            REPORT: begin
               // Statistics are frozen here; clear and report_req are ignored.
               if (out_ready) begin
                  state_reg <= empty_reg ? EMPTY : TRACK;
               end
            end

            default: begin
               state_reg <= EMPTY;
            end
         endcase
      end
   end

   assign min_out = min_reg;
   assign max_out = max_reg;
   assign count   = count_reg;
   assign empty   = empty_reg;
   assign trend_e = trend_e_reg;
   assign trend_l = trend_l_reg;
   assign trend_g = trend_g_reg;

endmodule
